// File: rtl/reg_bank_rw_bounds.sv
// Bounded configuration register bank: per-channel [min, max] write window with
// reject/clamp handling, sticky W1C alarms and a saturating violation counter.
module reg_bank_rw_bounds #(
  parameter int P_WIDTH    = 8,
  parameter int P_CHANNELS = 4,
  parameter int P_ADDR_W   = 2,
  parameter int P_CNT_W    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [P_CHANNELS*P_WIDTH-1:0] init,
  input  logic [P_CHANNELS*P_WIDTH-1:0] bound_min,
  input  logic [P_CHANNELS*P_WIDTH-1:0] bound_max,
  input  logic                          mode_clamp,
  input  logic [P_ADDR_W-1:0]           addr,
  input  logic                          reg_write,
  input  logic                          reg_read,
  input  logic [P_WIDTH-1:0]            data_in,
  input  logic [P_CHANNELS-1:0]         alarm_clear,
  output logic [P_WIDTH-1:0]            data_out,
  output logic                          read_valid,
  output logic [P_CHANNELS*P_WIDTH-1:0] values_q,
  output logic                          alarm_pulse,
  output logic [P_CHANNELS-1:0]         alarm_sticky,
  output logic                          addr_err,
  output logic [P_CNT_W-1:0]            viol_count
);

  // One extra bit so the limit is representable when 2**P_ADDR_W == P_CHANNELS.
  localparam logic [P_ADDR_W:0]  CH_LIMIT = (P_ADDR_W+1)'(P_CHANNELS);
  localparam logic [P_CNT_W-1:0] CNT_MAX  = '1;

  logic [P_WIDTH-1:0]    regs [P_CHANNELS];
  logic                  addr_ok;
  logic [P_CHANNELS-1:0] sel;
  logic [P_WIDTH-1:0]    cur_val;
  logic [P_WIDTH-1:0]    cur_min;
  logic [P_WIDTH-1:0]    cur_max;
  logic                  misconf;
  logic                  above;
  logic                  below;
  logic                  wr_hit;
  logic                  viol;
  logic                  wr_load;
  logic [P_WIDTH-1:0]    wr_data;
  logic [P_CHANNELS-1:0] sticky_set;

  assign addr_ok = ({1'b0, addr} < CH_LIMIT);

  always_comb begin
    sel     = '0;
    cur_val = '0;
    cur_min = '0;
    cur_max = '0;
    for (int k = 0; k < P_CHANNELS; k++) begin
      if (addr_ok && (addr == P_ADDR_W'(k))) begin
        sel[k]  = 1'b1;
        cur_val = regs[k];
        cur_min = bound_min[k*P_WIDTH +: P_WIDTH];
        cur_max = bound_max[k*P_WIDTH +: P_WIDTH];
      end
    end
  end

  assign misconf = (cur_min > cur_max);
  assign above   = (data_in > cur_max);
  assign below   = (data_in < cur_min);
  assign wr_hit  = reg_write && addr_ok;
  assign viol    = wr_hit && (misconf || above || below);

  // A misconfigured window never loads, even in clamp mode.
  always_comb begin
    wr_load = 1'b0;
    wr_data = data_in;
    if (wr_hit && !misconf) begin
      if (above) begin
        wr_load = mode_clamp;
        wr_data = cur_max;
      end else if (below) begin
        wr_load = mode_clamp;
        wr_data = cur_min;
      end else begin
        wr_load = 1'b1;
      end
    end
  end

  assign sticky_set = viol ? sel : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < P_CHANNELS; k++) begin
        regs[k] <= init[k*P_WIDTH +: P_WIDTH];
      end
      data_out     <= '0;
      read_valid   <= 1'b0;
      alarm_pulse  <= 1'b0;
      alarm_sticky <= '0;
      addr_err     <= 1'b0;
      viol_count   <= '0;
    end else begin
      for (int k = 0; k < P_CHANNELS; k++) begin
        if (wr_load && sel[k]) regs[k] <= wr_data;
      end
      if (reg_read) data_out <= addr_ok ? cur_val : '0;
      read_valid   <= reg_read;
      addr_err     <= (reg_write || reg_read) && !addr_ok;
      alarm_pulse  <= viol;
      // Set after clear so a same-cycle violation wins.
      alarm_sticky <= (alarm_sticky & ~alarm_clear) | sticky_set;
      if (viol && (viol_count != CNT_MAX)) viol_count <= viol_count + P_CNT_W'(1);
    end
  end

  always_comb begin
    values_q = '0;
    for (int k = 0; k < P_CHANNELS; k++) begin
      values_q[k*P_WIDTH +: P_WIDTH] = regs[k];
    end
  end

endmodule

// File: tb/tb_reg_bank_rw_bounds.sv
// Bench for reg_bank_rw_bounds: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the bank.
module tb_reg_bank_rw_bounds;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int AW  = 3;
  localparam int CW  = 2;
  localparam int CMAX = 3;

  logic          clock;
  logic          reset;
  logic [CH*W-1:0] init;
  logic [CH*W-1:0] bound_min;
  logic [CH*W-1:0] bound_max;
  logic          mode_clamp;
  logic [AW-1:0] addr;
  logic          reg_write;
  logic          reg_read;
  logic [W-1:0]  data_in;
  logic [CH-1:0] alarm_clear;
  logic [W-1:0]  data_out;
  logic          read_valid;
  logic [CH*W-1:0] values_q;
  logic          alarm_pulse;
  logic [CH-1:0] alarm_sticky;
  logic          addr_err;
  logic [CW-1:0] viol_count;

  reg_bank_rw_bounds #(.P_WIDTH(W), .P_CHANNELS(CH), .P_ADDR_W(AW), .P_CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .init(init), .bound_min(bound_min),
    .bound_max(bound_max), .mode_clamp(mode_clamp), .addr(addr),
    .reg_write(reg_write), .reg_read(reg_read), .data_in(data_in),
    .alarm_clear(alarm_clear), .data_out(data_out), .read_valid(read_valid),
    .values_q(values_q), .alarm_pulse(alarm_pulse), .alarm_sticky(alarm_sticky),
    .addr_err(addr_err), .viol_count(viol_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_mis = 0;

  int       m_val [CH];
  logic [CH-1:0] m_sticky;
  int       m_cnt;
  logic [W-1:0] m_dout;
  logic     m_rv;
  logic     m_pulse;
  logic     m_aerr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour, evaluated from the inputs present at the clock edge.
  task automatic model_step();
    int a, lo, hi, d;
    bit ok, v;
    if (reset) begin
      for (int k = 0; k < CH; k++) m_val[k] = int'(init[k*W +: W]);
      m_sticky = '0; m_cnt = 0; m_dout = '0; m_rv = 0; m_pulse = 0; m_aerr = 0;
    end else begin
      a  = int'(addr);
      d  = int'(data_in);
      ok = (a < CH);
      v  = 0;
      m_rv   = reg_read;
      m_aerr = (reg_read || reg_write) && !ok;
      if (reg_read) m_dout = ok ? W'(m_val[a]) : '0;
      if (reg_write && ok) begin
        lo = int'(bound_min[a*W +: W]);
        hi = int'(bound_max[a*W +: W]);
        if (lo > hi) v = 1;
        else if (d > hi) begin v = 1; if (mode_clamp) m_val[a] = hi; end
        else if (d < lo) begin v = 1; if (mode_clamp) m_val[a] = lo; end
        else m_val[a] = d;
      end
      m_pulse  = v;
      if (v && m_cnt < CMAX) m_cnt++;
      m_sticky = m_sticky & ~alarm_clear;
      if (v) m_sticky[a] = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [CH*W-1:0] exp_vals;
    for (int k = 0; k < CH; k++) exp_vals[k*W +: W] = W'(m_val[k]);
    check_val("values_q", 32'(values_q), 32'(exp_vals));
    check_val("data_out", 32'(data_out), 32'(m_dout));
    check_val("read_valid", 32'(read_valid), 32'(m_rv));
    check_val("alarm_pulse", 32'(alarm_pulse), 32'(m_pulse));
    check_val("alarm_sticky", 32'(alarm_sticky), 32'(m_sticky));
    check_val("addr_err", 32'(addr_err), 32'(m_aerr));
    check_val("viol_count", 32'(viol_count), 32'(m_cnt));
  endtask

  task automatic do_cycle();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; reg_write = 0; reg_read = 0; alarm_clear = '0;
  endtask

  task automatic set_bounds(input int ch, input logic [7:0] lo, input logic [7:0] hi);
    bound_min[ch*W +: W] = lo;
    bound_max[ch*W +: W] = hi;
  endtask

  task automatic wr_op(input int a, input logic [7:0] d);
    addr = AW'(a); data_in = d; reg_write = 1;
    do_cycle();
    idle();
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    do_cycle();
    idle();
  endtask

  initial begin
    init        = 32'h4030_2010;
    bound_min   = '0;
    bound_max   = '1;
    mode_clamp  = 0;
    addr        = '0;
    data_in     = '0;
    idle();
    reset = 1;
    do_cycle();
    do_cycle();
    idle();
    check_val("reset_values", 32'(values_q), 32'h4030_2010);
    check_val("reset_count", 32'(viol_count), 32'd0);

    // Reject mode on channel 1.
    set_bounds(1, 8'h10, 8'h80);
    wr_op(1, 8'h10);
    check_val("rej_lo_edge", 32'(values_q[15:8]), 32'h10);
    wr_op(1, 8'h80);
    wr_op(1, 8'h81);
    check_val("rej_above_pulse", 32'(alarm_pulse), 32'd1);
    wr_op(1, 8'h0F);
    check_val("rej_hold", 32'(values_q[15:8]), 32'h80);
    check_val("rej_sticky", 32'(alarm_sticky), 32'b0010);
    check_val("rej_count", 32'(viol_count), 32'd2);
    do_cycle();
    check_val("pulse_one_cycle", 32'(alarm_pulse), 32'd0);

    // Clamp mode on channel 2, then a misconfigured window.
    mode_clamp = 1;
    set_bounds(2, 8'h10, 8'h80);
    wr_op(2, 8'hFF);
    check_val("clamp_hi", 32'(values_q[23:16]), 32'h80);
    wr_op(2, 8'h00);
    check_val("clamp_lo", 32'(values_q[23:16]), 32'h10);
    set_bounds(2, 8'h90, 8'h80);
    wr_op(2, 8'h85);
    check_val("misconf_hold", 32'(values_q[23:16]), 32'h10);
    check_val("misconf_pulse", 32'(alarm_pulse), 32'd1);
    set_bounds(2, 8'h10, 8'h80);

    // Same-cycle read and write of channel 3; out-of-range access.
    addr = 3; data_in = 8'h55; reg_write = 1; reg_read = 1;
    do_cycle(); idle();
    check_val("rw_old_data", 32'(data_out), 32'h40);
    check_val("rw_new_value", 32'(values_q[31:24]), 32'h55);
    addr = 5; data_in = 8'h11; reg_write = 1; reg_read = 1;
    do_cycle(); idle();
    check_val("oob_err", 32'(addr_err), 32'd1);
    check_val("oob_data", 32'(data_out), 32'd0);
    check_val("oob_rv", 32'(read_valid), 32'd1);
    do_cycle();

    // Clear versus set on the same channel.
    do_reset();
    mode_clamp = 0;
    addr = 1; data_in = 8'hFF; reg_write = 1; alarm_clear = 4'b0010;
    do_cycle(); idle();
    check_val("set_wins", 32'(alarm_sticky), 32'b0010);
    alarm_clear = 4'b0010;
    do_cycle(); idle();
    check_val("clear_alone", 32'(alarm_sticky), 32'b0000);

    // Saturation with a 2-bit counter, back-to-back violations.
    for (int i = 0; i < 5; i++) begin
      addr = 1; data_in = 8'h00; reg_write = 1;
      do_cycle();
    end
    idle();
    check_val("sat_count", 32'(viol_count), 32'd3);

    // Reset coinciding with a violating write.
    reset = 1; addr = 1; data_in = 8'hFF; reg_write = 1;
    do_cycle(); idle();
    check_val("rst_viol_pulse", 32'(alarm_pulse), 32'd0);
    check_val("rst_viol_count", 32'(viol_count), 32'd0);
    check_val("rst_viol_sticky", 32'(alarm_sticky), 32'd0);
    do_cycle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [7:0] lo, hi;
        int ch;
        ch = $urandom_range(0, CH-1);
        lo = 8'($urandom_range(0, 255));
        hi = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0 && lo > hi) begin
          set_bounds(ch, hi, lo);
        end else begin
          set_bounds(ch, lo, hi);
        end
      end
      reset       = ($urandom_range(0, 59) == 0);
      reg_write   = $urandom_range(0, 1) == 1;
      reg_read    = $urandom_range(0, 1) == 1;
      addr        = AW'($urandom_range(0, 7));
      data_in     = 8'($urandom_range(0, 255));
      mode_clamp  = $urandom_range(0, 1) == 1;
      alarm_clear = ($urandom_range(0, 5) == 0) ? CH'($urandom_range(0, 15)) : '0;
      do_cycle();
    end
    idle();
    do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
